pot_mouse_emu: RTL

Multi-port successor to the single-port C1351 proportional-mouse emulator, feeding SID POTX/POTY inputs from MiSTer PS/2 mouse packets. Each port is independently selectable as off, C1351 mouse (wrapping 6-bit position with dither) or absolute paddle (saturating 8-bit position). Packets are accumulated with optional sub-step scaling. Sits between hps_io mouse output and the CIA/SID pot multiplexer.

---
 rtl/pot_mouse_pkg.sv | 31 +++
 rtl/pot_axis_acc.sv | 67 ++++++
 rtl/pot_mouse_emu.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pot_mouse_pkg.sv
// Shared constants for the multi-port proportional mouse / paddle emulator:
// port modes, PS/2 packet field positions and dither LFSR definition.
package pot_mouse_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_MOUSE  = 2'b01,
    MODE_PADDLE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int unsigned PKT_W       = 25;
  localparam int unsigned PKT_TOG     = 24;
  localparam int unsigned PKT_DY_LSB  = 16;
  localparam int unsigned PKT_DX_LSB  = 8;
  localparam int unsigned PKT_YOVF    = 7;
  localparam int unsigned PKT_XOVF    = 6;
  localparam int unsigned PKT_YSGN    = 5;
  localparam int unsigned PKT_XSGN    = 4;
  localparam int unsigned PKT_BTN_LSB = 0;

  localparam int unsigned LFSR_W     = 17;
  localparam int unsigned LFSR_TAP_A = 16;
  localparam int unsigned LFSR_TAP_B = 13;
  localparam logic [16:0] LFSR_SEED  = 17'h00001;

  function automatic logic mode_active(mode_e m);
    return (m == MODE_MOUSE) || (m == MODE_PADDLE);
  endfunction

endpackage

// File: rtl/pot_axis_acc.sv
// One axis position accumulator: decodes a PS/2 delta (with overflow clamp)
// and adds it with wrap (mouse) or saturation (paddle); reloads on mode change.
module pot_axis_acc
  import pot_mouse_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 0,
  parameter logic [7:0]  PADDLE_INIT = 8'd128
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode,
  input  logic       i_reload,
  input  logic       i_pkt,
  input  logic [7:0] i_byte,
  input  logic       i_sign,
  input  logic       i_ovf,
  output logic [7:0] o_pos
);

  localparam int unsigned W = 8 + SCALE_SHIFT;
  localparam logic [W-1:0] LP_PAD_INIT = W'(PADDLE_INIT) << SCALE_SHIFT;

  mode_e              w_mode;
  logic signed [8:0]  w_delta;
  logic signed [W+1:0] w_sum;
  logic [W-1:0]       r_acc;
  logic [W-1:0]       w_acc_nxt;

  assign w_mode = mode_e'(i_mode);

  always_comb begin
    if (i_ovf) w_delta = i_sign ? 9'sh100 : 9'sh0FF;
    else       w_delta = $signed({i_sign, i_byte});
  end

  // Two guard bits: bit W+1 flags underflow, bit W flags overflow past full scale.
  assign w_sum = $signed({2'b00, r_acc}) + $signed({{(W-7){w_delta[8]}}, w_delta});

  always_comb begin
    w_acc_nxt = r_acc;
    if (i_reload) begin
      case (w_mode)
        MODE_MOUSE:  w_acc_nxt = '0;
        MODE_PADDLE: w_acc_nxt = LP_PAD_INIT;
        default:     w_acc_nxt = r_acc;
      endcase
    end else if (i_pkt) begin
      case (w_mode)
        MODE_MOUSE: w_acc_nxt = w_sum[W-1:0];
        MODE_PADDLE: begin
          if (w_sum[W+1])  w_acc_nxt = '0;
          else if (w_sum[W]) w_acc_nxt = '1;
          else             w_acc_nxt = w_sum[W-1:0];
        end
        default: w_acc_nxt = r_acc;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_acc <= '0;
    else          r_acc <= w_acc_nxt;
  end

  assign o_pos = r_acc[SCALE_SHIFT+7:SCALE_SHIFT];

endmodule

// File: rtl/pot_mouse_emu.sv
// Multi-port PS/2 mouse to SID POTX/POTY emulator: per-port packet/mode edge
// detection, shared dither LFSR and registered pot/button formatting.
module pot_mouse_emu
  import pot_mouse_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned DITHER_EN   = 1,
  parameter logic [7:0]  PADDLE_INIT = 8'd128
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [25*NUM_PORTS-1:0]  ps2_mouse,
  input  logic [2*NUM_PORTS-1:0]   mode,
  output logic [8*NUM_PORTS-1:0]   pot_x,
  output logic [8*NUM_PORTS-1:0]   pot_y,
  output logic [2*NUM_PORTS-1:0]   button
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              r_primed;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr   <= LFSR_SEED;
      r_primed <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
      r_primed <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int unsigned LP_DX = (8 * p) % LFSR_W;
    localparam int unsigned LP_DY = (8 * p + 8) % LFSR_W;

    logic [PKT_W-1:0] w_pkt;
    mode_e            w_mode;
    mode_e            r_mode;
    logic             r_tog;
    logic             w_accept;
    logic             w_mode_chg;
    logic             w_dith_x;
    logic             w_dith_y;
    logic [7:0]       w_pos_x;
    logic [7:0]       w_pos_y;
    logic [7:0]       w_fmt_x;
    logic [7:0]       w_fmt_y;
    logic [7:0]       r_pot_x;
    logic [7:0]       r_pot_y;
    logic [1:0]       r_btn;
    logic             w_unused;

    assign w_pkt      = ps2_mouse[PKT_W*p +: PKT_W];
    assign w_mode     = mode_e'(mode[2*p +: 2]);
    assign w_mode_chg = (w_mode != r_mode);
    assign w_accept   = r_primed && (w_pkt[PKT_TOG] != r_tog);
    assign w_dith_x   = (DITHER_EN != 0) ? r_lfsr[LP_DX] : 1'b0;
    assign w_dith_y   = (DITHER_EN != 0) ? r_lfsr[LP_DY] : 1'b0;
    assign w_unused   = ^w_pkt[3:2];

    pot_axis_acc #(
      .SCALE_SHIFT (SCALE_SHIFT),
      .PADDLE_INIT (PADDLE_INIT)
    ) u_acc_x (
      .i_clk    (clk_sys),
      .i_rst_n  (reset_n),
      .i_mode   (mode[2*p +: 2]),
      .i_reload (w_mode_chg),
      .i_pkt    (w_accept),
      .i_byte   (w_pkt[PKT_DX_LSB +: 8]),
      .i_sign   (w_pkt[PKT_XSGN]),
      .i_ovf    (w_pkt[PKT_XOVF]),
      .o_pos    (w_pos_x)
    );

    pot_axis_acc #(
      .SCALE_SHIFT (SCALE_SHIFT),
      .PADDLE_INIT (PADDLE_INIT)
    ) u_acc_y (
      .i_clk    (clk_sys),
      .i_rst_n  (reset_n),
      .i_mode   (mode[2*p +: 2]),
      .i_reload (w_mode_chg),
      .i_pkt    (w_accept),
      .i_byte   (w_pkt[PKT_DY_LSB +: 8]),
      .i_sign   (w_pkt[PKT_YSGN]),
      .i_ovf    (w_pkt[PKT_YOVF]),
      .o_pos    (w_pos_y)
    );

    // Formatting follows the registered mode so it lines up with the accumulator it reads.
    always_comb begin
      w_fmt_x = 8'hFF;
      w_fmt_y = 8'hFF;
      case (r_mode)
        MODE_MOUSE: begin
          w_fmt_x = ~{1'b0, w_pos_x[5:0], w_dith_x};
          w_fmt_y = ~{1'b0, w_pos_y[5:0], w_dith_y};
        end
        MODE_PADDLE: begin
          w_fmt_x = w_pos_x;
          w_fmt_y = w_pos_y;
        end
        default: begin
          w_fmt_x = 8'hFF;
          w_fmt_y = 8'hFF;
        end
      endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_tog   <= 1'b0;
        r_mode  <= MODE_OFF;
        r_pot_x <= 8'hFF;
        r_pot_y <= 8'hFF;
        r_btn   <= '0;
      end else begin
        r_tog   <= w_pkt[PKT_TOG];
        r_mode  <= w_mode;
        r_pot_x <= w_fmt_x;
        r_pot_y <= w_fmt_y;
        r_btn   <= mode_active(w_mode) ? w_pkt[PKT_BTN_LSB +: 2] : 2'b00;
      end
    end

    assign pot_x[8*p +: 8]  = r_pot_x;
    assign pot_y[8*p +: 8]  = r_pot_y;
    assign button[2*p +: 2] = r_btn;
  end

endmodule
